// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mem_port_arbiter_if : requester + memory-side bus of the shared memory port
// Revision 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          sel;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          timeout_err;

  // Arbiter side
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_done, d_done, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata,
           timeout_err
  );

  // Requesters and memory side
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_done, d_done, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata,
           timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mem_port_arbiter : fetch/data arbiter for one unified memory port
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] timer;

  logic          grant_data;
  logic          grant_we;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;

  // Data wins unless fetch has waited through STARVE_MAX data grants.
  assign grant_data  = bus.d_req && !(bus.if_req && (starve_cnt == STARVE_LIMIT));
  assign grant_we    = grant_data ? bus.d_we    : 1'b0;
  assign grant_addr  = grant_data ? bus.d_addr  : bus.if_addr;
  assign grant_wdata = grant_data ? bus.d_wdata : {DW{1'b0}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      timer           <= '0;
      bus.sel         <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= {AW{1'b0}};
      bus.mem_wdata   <= {DW{1'b0}};
      bus.rdata       <= {DW{1'b0}};
      bus.if_done     <= 1'b0;
      bus.d_done      <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req || bus.if_req) begin
            bus.sel       <= grant_data;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= grant_we;
            bus.mem_addr  <= grant_addr;
            bus.mem_wdata <= grant_wdata;
            timer         <= '0;
            state         <= BUSY;
            if (!grant_data)
              starve_cnt <= '0;
            else if (bus.if_req && (starve_cnt != STARVE_LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        BUSY: begin
          timer <= timer + 1'b1;
          if (bus.mem_ready) begin
            if (!bus.mem_we)
              bus.rdata <= bus.mem_rdata;
            bus.mem_req <= 1'b0;
            bus.if_done <= ~bus.sel;
            bus.d_done  <= bus.sel;
            state       <= DONE;
          end else if ((TIMEOUT != 0) && (timer == TIMER_LAST)) begin
            // Abort: all-ones read data flags the failed access to the requester.
            bus.rdata       <= {DW{1'b1}};
            bus.timeout_err <= 1'b1;
            bus.mem_req     <= 1'b0;
            bus.if_done     <= ~bus.sel;
            bus.d_done      <= bus.sel;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.if_done <= 1'b0;
          bus.d_done  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_port_arbiter : directed bench with a transaction-level reference model
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 waiting, 1 memory access, 2 completion cycle.
  int            m_phase, m_busy, m_starve;
  logic          e_sel, e_req, e_we, e_ifd, e_dd, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic          fetch_wins;
  assign fetch_wins = bus.if_req && (!bus.d_req || m_starve >= STARVE_MAX);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_busy <= 0; m_starve <= 0;
      e_sel <= 0; e_req <= 0; e_we <= 0; e_ifd <= 0; e_dd <= 0; e_err <= 0;
      e_addr <= '0; e_wdata <= '0; e_rdata <= '0;
    end else begin
      case (m_phase)
        0: if (bus.if_req || bus.d_req) begin
          m_phase <= 1; m_busy <= 0; e_req <= 1;
          if (fetch_wins) begin
            e_sel <= 0; e_we <= 0; e_addr <= bus.if_addr; e_wdata <= '0; m_starve <= 0;
          end else begin
            e_sel <= 1; e_we <= bus.d_we; e_addr <= bus.d_addr; e_wdata <= bus.d_wdata;
            if (bus.if_req)
              m_starve <= (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
          end
        end
        1: begin
          m_busy <= m_busy + 1;
          if (bus.mem_ready || (TIMEOUT != 0 && m_busy + 1 == TIMEOUT)) begin
            m_phase <= 2; e_req <= 0; e_ifd <= !e_sel; e_dd <= e_sel;
            if (bus.mem_ready) begin
              if (!e_we) e_rdata <= bus.mem_rdata;
            end else begin
              e_rdata <= '1; e_err <= 1;
            end
          end
        end
        default: begin
          e_ifd <= 0; e_dd <= 0; m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("mem_req",     bus.mem_req,     e_req);
    chk("sel",         bus.sel,         e_sel);
    chk("mem_we",      bus.mem_we,      e_we);
    chk("mem_addr",    bus.mem_addr,    e_addr);
    chk("mem_wdata",   bus.mem_wdata,   e_wdata);
    chk("rdata",       bus.rdata,       e_rdata);
    chk("if_done",     bus.if_done,     e_ifd);
    chk("d_done",      bus.d_done,      e_dd);
    chk("timeout_err", bus.timeout_err, e_err);
  end

  // Memory responder: ready on the (rsp_delay+1)-th cycle of mem_req.
  int rsp_delay   = 0;
  bit force_ready = 0;
  int rsp_cnt     = 0;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      rsp_cnt       <= rsp_cnt + 1;
      bus.mem_ready <= (rsp_cnt + 1 == rsp_delay + 1);
    end else begin
      rsp_cnt       <= 0;
      bus.mem_ready <= force_ready;
    end
  end

  int   n;
  logic gi, gd;
  bit   exp_grant [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  task automatic wait_done(input int limit, output int cnt, output logic got_if, output logic got_d);
    cnt = 0;
    while (cnt < limit && !(bus.if_done || bus.d_done)) begin
      @(negedge clk);
      cnt++;
    end
    got_if = bus.if_done;
    got_d  = bus.d_done;
    chk("done_within_bound", bus.if_done || bus.d_done, 1);
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.timeout_err, 0);
    rst_n = 1;
    @(negedge clk);

    // 1: fetch only, ready on the second BUSY cycle
    bus.if_addr = 32'h100; bus.if_req = 1; bus.mem_rdata = 32'hDEADBEEF; rsp_delay = 1;
    wait_done(20, n, gi, gd);
    chk("t1_if_done", gi, 1);
    chk("t1_d_done", gd, 0);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_sel", bus.sel, 0);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t1_latency_cycles", n + 1, 4);
    bus.if_req = 0;
    @(negedge clk);
    chk("t1_done_one_pulse", bus.if_done, 0);

    // 2: simultaneous requests, data store first then fetch
    bus.if_addr = 32'h180; bus.if_req = 1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h55;
    bus.mem_rdata = 32'h12345678; rsp_delay = 0;
    @(negedge clk);
    chk("t2_sel", bus.sel, 1);
    chk("t2_mem_we", bus.mem_we, 1);
    chk("t2_mem_wdata", bus.mem_wdata, 32'h55);
    chk("t2_mem_addr", bus.mem_addr, 32'h200);
    wait_done(20, n, gi, gd);
    chk("t2_d_done", gd, 1);
    chk("t2_rdata_kept", bus.rdata, 32'hDEADBEEF);
    bus.d_req = 0; bus.d_we = 0;
    @(negedge clk);
    wait_done(20, n, gi, gd);
    chk("t2_fetch_done", gi, 1);
    chk("t2_fetch_addr", bus.mem_addr, 32'h180);
    chk("t2_fetch_wdata", bus.mem_wdata, 0);
    chk("t2_fetch_rdata", bus.rdata, 32'h12345678);
    bus.if_req = 0;
    @(negedge clk);

    // 3: both held, starvation forces every fifth grant to fetch
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    bus.if_req = 1; bus.if_addr = 32'h400; bus.mem_rdata = 32'hA5A5A5A5;
    for (int k = 0; k < 10; k++) begin
      int w;
      w = 0;
      while (!bus.mem_req && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("t3_grant%0d_sel", k), bus.sel, exp_grant[k]);
      @(negedge clk);
    end
    bus.d_req = 0; bus.if_req = 0;
    @(negedge clk);

    // 6: ready outside BUSY ignored; ready on the last allowed BUSY cycle completes
    force_ready = 1;
    repeat (4) @(negedge clk);
    chk("t6_idle_no_req", bus.mem_req, 0);
    chk("t6_idle_no_done", bus.d_done | bus.if_done, 0);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.mem_rdata = 32'h0BADF00D;
    rsp_delay = TIMEOUT - 1;
    wait_done(30, n, gi, gd);
    chk("t6_d_done", gd, 1);
    chk("t6_rdata", bus.rdata, 32'h0BADF00D);
    chk("t6_no_err", bus.timeout_err, 0);
    chk("t6_cycles", n, TIMEOUT + 1);
    bus.d_req = 0;
    @(negedge clk);
    chk("t6_done_ready_ignored", bus.mem_req, 0);
    force_ready = 0;
    @(negedge clk);

    // 4: timeout abort, then a normal transaction
    bus.if_req = 1; bus.if_addr = 32'h600; bus.mem_rdata = 32'h11111111; rsp_delay = 1000;
    wait_done(30, n, gi, gd);
    chk("t4_if_done", gi, 1);
    chk("t4_rdata", bus.rdata, 32'hFFFFFFFF);
    chk("t4_err", bus.timeout_err, 1);
    chk("t4_cycles", n, TIMEOUT + 1);
    bus.if_req = 0;
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h700; bus.mem_rdata = 32'h22222222;
    rsp_delay = 0;
    wait_done(20, n, gi, gd);
    chk("t4_next_d_done", gd, 1);
    chk("t4_next_rdata", bus.rdata, 32'h22222222);
    chk("t4_err_sticky", bus.timeout_err, 1);
    bus.d_req = 0;
    @(negedge clk);

    // 5: reset in the middle of BUSY
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h800; bus.d_wdata = 32'h99; rsp_delay = 1000;
    repeat (3) @(negedge clk);
    chk("t5_busy_before_rst", bus.mem_req, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_mem_req", bus.mem_req, 0);
    chk("t5_rst_sel", bus.sel, 0);
    chk("t5_rst_err", bus.timeout_err, 0);
    chk("t5_rst_done", bus.d_done | bus.if_done, 0);
    chk("t5_rst_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1; rsp_delay = 0;
    wait_done(20, n, gi, gd);
    chk("t5_after_d_done", gd, 1);
    chk("t5_after_addr", bus.mem_addr, 32'h800);
    chk("t5_after_wdata", bus.mem_wdata, 32'h99);
    bus.d_req = 0; bus.d_we = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
